// File: rtl/spi_wb_master.sv
// -----------------------------------------------------------------------------
// spi_wb_master
//   Wishbone-slave-controlled SPI master (mode 0, MSB first, 8-bit frames).
//
//   Register map (byte address, only ADR_I[3:2] decoded when ADR_I[7:4]==0):
//     0x00 CTRL   [3:0] R/W  {ASS, IE, SSM, EN}
//     0x04 DIV    [7:0] R/W  SCLK half-period minus one, in CLK_I cycles
//     0x08 DATA   W: TX byte (starts a transfer when EN=1)  R: RX byte, clears DONE
//     0x0C STATUS R: {OVR, DONE, BUSY}  W: 1 to bit1 clears DONE, 1 to bit2 clears OVR
//
//   Ports:
//     CLK_I, RST_I           clock, synchronous active-high reset
//     ADR_I, DAT_I, DAT_O    Wishbone address / write data / read data
//     CYC_I, STB_I, WE_I     Wishbone cycle, strobe, write enable
//     ACK_O                  Wishbone acknowledge (1-cycle pulse)
//     SCLK_O, MOSI_O, MISO_I SPI clock and data lines
//     SS_O                   SPI slave select, active low
//     IRQ_O                  transfer-done interrupt (IE & DONE, registered)
// -----------------------------------------------------------------------------
module spi_wb_master #(
  parameter logic [7:0] DIV_RST = 8'd3
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [7:0]  ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  output logic        SCLK_O,
  output logic        MOSI_O,
  input  logic        MISO_I,
  output logic        SS_O,
  output logic        IRQ_O
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [3:0] LAST_TOGGLE = 4'd15;

  // Control / architectural registers
  logic        ack;
  logic [3:0]  ctrl;
  logic [7:0]  div;
  logic [7:0]  tx;
  logic [7:0]  rx;
  logic        done;
  logic        ovr;
  logic        irq;
  logic [1:0]  state;
  logic        sclk;
  logic        mosi;

  // Shift datapath
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [7:0]  div_act;
  logic [7:0]  clk_cnt;
  logic [3:0]  tog_cnt;

  logic        in_map;
  logic        wr_acc;
  logic        rd_acc;
  logic        ctrl_wr;
  logic        div_wr;
  logic        data_wr;
  logic        data_rd;
  logic        stat_wr;
  logic        busy;
  logic        en_next;
  logic        start;
  logic        tick;
  logic        rise;
  logic        fall_shift;
  logic [31:0] rd_data;

  // Bus decode: everything qualifies on the ACK cycle, so side effects happen once.
  assign in_map  = (ADR_I[7:4] == 4'd0);
  assign wr_acc  = ack & WE_I & in_map;
  assign rd_acc  = ack & ~WE_I & in_map;
  assign ctrl_wr = wr_acc & (ADR_I[3:2] == REG_CTRL);
  assign div_wr  = wr_acc & (ADR_I[3:2] == REG_DIV);
  assign data_wr = wr_acc & (ADR_I[3:2] == REG_DATA);
  assign stat_wr = wr_acc & (ADR_I[3:2] == REG_STATUS);
  assign data_rd = rd_acc & (ADR_I[3:2] == REG_DATA);

  assign busy = (state != ST_IDLE);

  // Look ahead at a CTRL write so clearing EN stops the shift in the very next cycle.
  assign en_next = ctrl_wr ? DAT_I[0] : ctrl[0];

  assign start      = (state == ST_IDLE) & data_wr & ctrl[0];
  assign tick       = (state == ST_SHIFT) & en_next & (clk_cnt == div_act);
  assign rise       = tick & ~sclk;
  // The 8th falling edge ends the frame; MOSI keeps the last bit after it.
  assign fall_shift = tick & sclk & (tog_cnt != LAST_TOGGLE);

  always_comb begin
    rd_data = '0;
    if (ack && in_map) begin
      case (ADR_I[3:2])
        REG_CTRL:   rd_data = {28'd0, ctrl};
        REG_DIV:    rd_data = {24'd0, div};
        REG_DATA:   rd_data = {24'd0, rx};
        REG_STATUS: rd_data = {29'd0, ovr, done, busy};
        default:    rd_data = '0;
      endcase
    end
  end

  assign DAT_O  = rd_data;
  assign ACK_O  = ack;
  assign SCLK_O = sclk;
  assign MOSI_O = mosi;
  assign IRQ_O  = irq;
  assign SS_O   = ~(ctrl[1] | (ctrl[3] & busy));

  // ---- Bus-side registers ----
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ack  <= 1'b0;
      ctrl <= 4'd0;
      div  <= DIV_RST;
      tx   <= 8'd0;
      rx   <= 8'd0;
      done <= 1'b0;
      ovr  <= 1'b0;
      irq  <= 1'b0;
    end else begin
      ack <= CYC_I & STB_I & ~ack;
      irq <= ctrl[2] & done;

      if (ctrl_wr)
        ctrl <= DAT_I[3:0];
      if (div_wr)
        div <= DAT_I[7:0];

      // A DATA write during a transfer is dropped and flagged as overrun.
      if (data_wr && !busy)
        tx <= DAT_I[7:0];

      if (data_wr && busy)
        ovr <= 1'b1;
      else if (stat_wr && DAT_I[2])
        ovr <= 1'b0;

      // Completion has priority over a simultaneous clear.
      if (state == ST_FINISH) begin
        rx   <= rx_sh;
        done <= 1'b1;
      end else if (data_rd || (stat_wr && DAT_I[1])) begin
        done <= 1'b0;
      end
    end
  end

  // ---- Transfer FSM and SPI outputs ----
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= ST_IDLE;
      sclk  <= 1'b0;
      mosi  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
            sclk  <= 1'b0;
            mosi  <= DAT_I[7];
          end
        end
        ST_SHIFT: begin
          if (!en_next) begin
            state <= ST_IDLE;
            sclk  <= 1'b0;
          end else if (tick) begin
            sclk <= ~sclk;
            if (fall_shift)
              mosi <= tx_sh[6];
            if (tog_cnt == LAST_TOGGLE)
              state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---- Shift datapath (reloaded at every start, no reset needed) ----
  always_ff @(posedge CLK_I) begin
    if (start) begin
      tx_sh   <= DAT_I[7:0];
      div_act <= div;
      clk_cnt <= 8'd0;
      tog_cnt <= 4'd0;
    end else if (tick) begin
      clk_cnt <= 8'd0;
      tog_cnt <= tog_cnt + 4'd1;
      if (rise)
        rx_sh <= {rx_sh[6:0], MISO_I};
      if (fall_shift)
        tx_sh <= {tx_sh[6:0], 1'b0};
    end else if (state == ST_SHIFT) begin
      clk_cnt <= clk_cnt + 8'd1;
    end
  end

  // TX is a write-only holding register; the transfer loads the shifter from the bus.
  logic unused_bits;
  assign unused_bits = ^{ADR_I[1:0], DAT_I[31:8], tx};

endmodule

// File: tb/tb_spi_wb_master.sv
module tb_spi_wb_master;

  localparam logic [7:0] DIV_RST = 8'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  adr = 8'd0;
  logic [31:0] dat_i = 32'd0;
  logic [31:0] dat_o;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic        ack, sclk, mosi, ss, irq;
  logic        miso, miso_r = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Monitor / SPI slave model state
  int         miso_mode = 0;   // 0 loopback, 1 pattern, 2 constant 1
  logic [7:0] miso_pat = 8'd0;
  int         bit_idx = 0;
  logic       prev_sclk = 1'b0;
  int         ss_low_cnt = 0, hi_run = 0, tog_seen = 0;
  int         hi_q[$];
  logic       mosi_q[$];

  always #5 clk = ~clk;

  assign miso = (miso_mode == 0) ? mosi : miso_r;

  spi_wb_master #(.DIV_RST(DIV_RST)) dut (
    .CLK_I(clk), .RST_I(rst), .ADR_I(adr), .DAT_I(dat_i), .DAT_O(dat_o),
    .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ACK_O(ack),
    .SCLK_O(sclk), .MOSI_O(mosi), .MISO_I(miso), .SS_O(ss), .IRQ_O(irq)
  );

  always @(negedge clk) begin
    if (ss === 1'b0) ss_low_cnt++;
    if (sclk !== prev_sclk) tog_seen++;
    if (sclk === 1'b1) hi_run++;
    else if (prev_sclk === 1'b1) begin hi_q.push_back(hi_run); hi_run = 0; end
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin mosi_q.push_back(mosi); bit_idx++; end
    prev_sclk = sclk;
    if (miso_mode == 2) miso_r = 1'b1;
    else if (bit_idx < 8) miso_r = miso_pat[7 - bit_idx];
    else miso_r = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic clear_mon();
    ss_low_cnt = 0; hi_run = 0; tog_seen = 0; bit_idx = 0;
    prev_sclk = sclk;
    hi_q.delete(); mosi_q.delete();
  endtask

  task automatic wb(input logic w, input logic [7:0] a, input logic [31:0] d, output logic [31:0] r);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; n = 0;
    do begin @(posedge clk); #1; n++; end while (ack !== 1'b1 && n < 8);
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL wb_ack addr=%h: got ack=%b required 1", a, ack);
    else pass_cnt++;
    r = dat_o;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] r);
    wb(1'b0, a, 32'd0, r);
  endtask

  task automatic wait_ss_high(input int bound);
    int n;
    n = 0;
    while (ss !== 1'b1 && n < bound) begin @(posedge clk); #1; n++; end
    total_cnt++;
    if (ss !== 1'b1) $display("FAIL wait_ss_high: got ss=%b required 1 within %0d cycles", ss, bound);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    total_cnt++;
    if ({ack, sclk, mosi, ss, irq} !== 5'b00010)
      $display("FAIL reset_outputs: got ack,sclk,mosi,ss,irq=%b required 00010", {ack, sclk, mosi, ss, irq});
    else pass_cnt++;
    total_cnt++;
    if (dat_o !== 32'd0) $display("FAIL reset_dat_o: got %h required 0", dat_o); else pass_cnt++;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h04;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (ack !== 1'b0) $display("FAIL ack_in_reset: got %b required 0", ack); else pass_cnt++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL ack_after_reset: got %b required 1", ack); else pass_cnt++;
    total_cnt++;
    if (dat_o !== {24'd0, DIV_RST}) $display("FAIL div_reset_read: got %h required %h", dat_o, DIV_RST); else pass_cnt++;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    begin
      logic [31:0] r;
      rd(8'h00, r); total_cnt++;
      if (r !== 32'd0) $display("FAIL reset_ctrl: got %h required 0", r); else pass_cnt++;
      rd(8'h08, r); total_cnt++;
      if (r !== 32'd0) $display("FAIL reset_rx: got %h required 0", r); else pass_cnt++;
      rd(8'h0C, r); total_cnt++;
      if (r !== 32'd0) $display("FAIL reset_status: got %h required 0", r); else pass_cnt++;
    end
  endtask

  task automatic test_regs();
    logic [31:0] r;
    logic [3:0]  c;
    logic [7:0]  d;
    for (int i = 0; i < 4; i++) begin
      c = 4'($urandom) & 4'hE;
      d = 8'($urandom_range(0, 255));
      wr(8'h00, {28'd0, c});
      rd(8'h00, r); total_cnt++;
      if (r !== {28'd0, c}) $display("FAIL ctrl_rw: got %h required %h", r, c); else pass_cnt++;
      total_cnt++;
      if (ss !== ~c[1]) $display("FAIL ss_manual: got %b required %b", ss, ~c[1]); else pass_cnt++;
      wr(8'h04, {24'd0, d});
      rd(8'h04, r); total_cnt++;
      if (r !== {24'd0, d}) $display("FAIL div_rw: got %h required %h", r, d); else pass_cnt++;
    end
    total_cnt++;
    if (dat_o !== 32'd0) $display("FAIL dat_o_idle: got %h required 0", dat_o); else pass_cnt++;
    wr(8'h14, 32'hAB);
    rd(8'h04, r); total_cnt++;
    if (r !== {24'd0, d}) $display("FAIL unmapped_write_ignored: got %h required %h", r, d); else pass_cnt++;
    rd(8'h14, r); total_cnt++;
    if (r !== 32'd0) $display("FAIL unmapped_read: got %h required 0", r); else pass_cnt++;
    // DATA write with EN=0: no transfer
    wr(8'h00, 32'h8);
    wr(8'h08, 32'h5A);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({ss, sclk} !== 2'b10) $display("FAIL en_off_no_xfer: got ss,sclk=%b required 10", {ss, sclk}); else pass_cnt++;
    end
    rd(8'h0C, r); total_cnt++;
    if (r !== 32'd0) $display("FAIL en_off_status: got %h required 0", r); else pass_cnt++;
    wr(8'h00, 32'h0);
  endtask

  task automatic test_loopback();
    logic [31:0] r;
    int bad;
    miso_mode = 0;
    wr(8'h04, 32'd0); wr(8'h00, 32'h9); wr(8'h0C, 32'h6);
    clear_mon();
    wr(8'h08, 32'hA5);
    wait_ss_high(100);
    repeat (2) @(posedge clk); #1;
    total_cnt++;
    if (ss_low_cnt != 17) $display("FAIL loop_ss_low: got %0d required 17", ss_low_cnt); else pass_cnt++;
    bad = 0;
    foreach (hi_q[i]) if (hi_q[i] != 1) bad++;
    total_cnt++;
    if (hi_q.size() != 8 || bad != 0 || tog_seen != 16)
      $display("FAIL loop_sclk: got pulses=%0d badwidth=%0d toggles=%0d required 8 0 16", hi_q.size(), bad, tog_seen);
    else pass_cnt++;
    rd(8'h0C, r); total_cnt++;
    if (r !== 32'h2) $display("FAIL loop_status_done: got %h required 2", r); else pass_cnt++;
    rd(8'h08, r); total_cnt++;
    if (r !== 32'hA5) $display("FAIL loop_rx: got %h required a5", r); else pass_cnt++;
    rd(8'h0C, r); total_cnt++;
    if (r !== 32'h0) $display("FAIL loop_status_clear: got %h required 0", r); else pass_cnt++;
  endtask

  task automatic test_fixed_pattern();
    logic [31:0] r;
    logic [7:0]  seq;
    miso_mode = 2;
    wr(8'h04, 32'd3); wr(8'h00, 32'h9); wr(8'h0C, 32'h6);
    clear_mon();
    wr(8'h08, 32'h3C);
    wait_ss_high(200);
    repeat (2) @(posedge clk); #1;
    seq = 8'd0;
    for (int i = 0; i < 8 && i < mosi_q.size(); i++) seq[7 - i] = mosi_q[i];
    total_cnt++;
    if (mosi_q.size() != 8 || seq !== 8'h3C) $display("FAIL fixed_mosi_seq: got %h (n=%0d) required 3c", seq, mosi_q.size()); else pass_cnt++;
    total_cnt++;
    if (ss_low_cnt != 65) $display("FAIL fixed_busy: got %0d required 65", ss_low_cnt); else pass_cnt++;
    rd(8'h08, r); total_cnt++;
    if (r !== 32'hFF) $display("FAIL fixed_rx: got %h required ff", r); else pass_cnt++;
    miso_mode = 0;
  endtask

  task automatic test_random_xfers();
    logic [31:0] r;
    logic [7:0]  tx, pat, exp_rx, seq;
    int          dv, mode, bad;
    for (int it = 0; it < 6; it++) begin
      dv = $urandom_range(0, 3); mode = $urandom_range(0, 1);
      tx = 8'($urandom); pat = 8'($urandom);
      exp_rx = (mode == 0) ? tx : pat;
      wr(8'h04, dv); wr(8'h00, 32'h9); wr(8'h0C, 32'h6);
      miso_mode = mode; miso_pat = pat;
      clear_mon();
      wr(8'h08, {24'd0, tx});
      wait_ss_high(300);
      repeat (2) @(posedge clk); #1;
      total_cnt++;
      if (ss_low_cnt != 16 * (dv + 1) + 1) $display("FAIL rand_busy: got %0d required %0d", ss_low_cnt, 16 * (dv + 1) + 1); else pass_cnt++;
      seq = 8'd0; bad = 0;
      for (int i = 0; i < 8 && i < mosi_q.size(); i++) seq[7 - i] = mosi_q[i];
      foreach (hi_q[i]) if (hi_q[i] != dv + 1) bad++;
      total_cnt++;
      if (seq !== tx || mosi_q.size() != 8) $display("FAIL rand_mosi: got %h required %h", seq, tx); else pass_cnt++;
      total_cnt++;
      if (hi_q.size() != 8 || bad != 0) $display("FAIL rand_sclk_high: got pulses=%0d bad=%0d required 8 0", hi_q.size(), bad); else pass_cnt++;
      rd(8'h0C, r); total_cnt++;
      if (r !== 32'h2) $display("FAIL rand_status: got %h required 2", r); else pass_cnt++;
      rd(8'h08, r); total_cnt++;
      if (r !== {24'd0, exp_rx}) $display("FAIL rand_rx: got %h required %h", r, exp_rx); else pass_cnt++;
    end
    miso_mode = 0;
  endtask

  task automatic test_overrun();
    logic [31:0] r;
    logic [7:0]  tx, seq;
    tx = 8'($urandom);
    if (tx == 8'h11) tx = 8'h22;
    miso_mode = 0;
    wr(8'h04, 32'd1); wr(8'h00, 32'h9); wr(8'h0C, 32'h6);
    clear_mon();
    wr(8'h08, {24'd0, tx});
    repeat (5) @(posedge clk); #1;
    wr(8'h08, 32'h11);
    wait_ss_high(200);
    repeat (2) @(posedge clk); #1;
    rd(8'h0C, r); total_cnt++;
    if (r !== 32'h6) $display("FAIL ovr_status: got %h required 6", r); else pass_cnt++;
    seq = 8'd0;
    for (int i = 0; i < 8 && i < mosi_q.size(); i++) seq[7 - i] = mosi_q[i];
    total_cnt++;
    if (seq !== tx) $display("FAIL ovr_sent_byte: got %h required %h", seq, tx); else pass_cnt++;
    wr(8'h0C, 32'h4);
    rd(8'h0C, r); total_cnt++;
    if (r !== 32'h2) $display("FAIL ovr_clear: got %h required 2", r); else pass_cnt++;
    rd(8'h08, r); total_cnt++;
    if (r !== {24'd0, tx}) $display("FAIL ovr_rx: got %h required %h", r, tx); else pass_cnt++;
  endtask

  task automatic test_div_during_busy();
    logic [31:0] r;
    wr(8'h04, 32'd0); wr(8'h00, 32'h9); wr(8'h0C, 32'h6);
    clear_mon();
    wr(8'h08, 32'h3);
    wr(8'h04, 32'd2);
    wait_ss_high(100);
    repeat (2) @(posedge clk); #1;
    total_cnt++;
    if (ss_low_cnt != 17) $display("FAIL div_busy_current: got %0d required 17", ss_low_cnt); else pass_cnt++;
    clear_mon();
    wr(8'h08, 32'h4);
    wait_ss_high(200);
    repeat (2) @(posedge clk); #1;
    total_cnt++;
    if (ss_low_cnt != 49) $display("FAIL div_busy_next: got %0d required 49", ss_low_cnt); else pass_cnt++;
    rd(8'h08, r); total_cnt++;
    if (r !== 32'h4) $display("FAIL div_busy_rx: got %h required 4", r); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [31:0] r;
    int n, t0;
    wr(8'h04, 32'd1); wr(8'h00, 32'h9); wr(8'h0C, 32'h6);
    clear_mon();
    wr(8'h08, 32'h96);
    n = 0;
    while (tog_seen < 5 && n < 60) begin @(posedge clk); #1; n++; end
    total_cnt++;
    if (tog_seen < 5) $display("FAIL abort_wait_toggle: got %0d toggles required 5", tog_seen); else pass_cnt++;
    wr(8'h00, 32'h8);
    total_cnt++;
    if ({ss, sclk} !== 2'b10) $display("FAIL abort_idle: got ss,sclk=%b required 10", {ss, sclk}); else pass_cnt++;
    t0 = tog_seen;
    repeat (6) @(posedge clk); #1;
    total_cnt++;
    if (tog_seen != t0 || sclk !== 1'b0) $display("FAIL abort_sclk_stopped: got toggles %0d->%0d sclk=%b required no change, 0", t0, tog_seen, sclk); else pass_cnt++;
    rd(8'h0C, r); total_cnt++;
    if (r !== 32'h0) $display("FAIL abort_status: got %h required 0", r); else pass_cnt++;
    rd(8'h08, r); total_cnt++;
    if (r !== 32'h4) $display("FAIL abort_rx_kept: got %h required 4", r); else pass_cnt++;
  endtask

  task automatic test_irq();
    logic [31:0] r;
    wr(8'h04, 32'd0); wr(8'h00, 32'hD); wr(8'h0C, 32'h6);
    clear_mon();
    wr(8'h08, 32'h5C);
    wait_ss_high(100);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_first_idle: got %b required 0", irq); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_rise: got %b required 1", irq); else pass_cnt++;
    rd(8'h08, r);
    @(posedge clk); #1;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_fall: got %b required 0", irq); else pass_cnt++;
    // DATA read landing on the FINISH cycle: DONE set must win
    clear_mon();
    wr(8'h08, 32'hC3);
    repeat (15) @(posedge clk); #1;
    rd(8'h08, r);
    rd(8'h0C, r); total_cnt++;
    if (r !== 32'h2) $display("FAIL done_set_wins: got %h required 2", r); else pass_cnt++;
    rd(8'h08, r); total_cnt++;
    if (r !== 32'hC3) $display("FAIL collision_rx: got %h required c3", r); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    wr(8'h04, 32'd2); wr(8'h00, 32'hF);
    clear_mon();
    wr(8'h08, 32'hF0);
    repeat (10) @(posedge clk); #1;
    total_cnt++;
    if (ss !== 1'b0) $display("FAIL mid_ss_low: got %b required 0", ss); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({ack, sclk, mosi, ss, irq} !== 5'b00010)
      $display("FAIL mid_reset_outputs: got ack,sclk,mosi,ss,irq=%b required 00010", {ack, sclk, mosi, ss, irq});
    else pass_cnt++;
    rst = 1'b0;
    rd(8'h04, r); total_cnt++;
    if (r !== {24'd0, DIV_RST}) $display("FAIL mid_div_reset: got %h required %h", r, DIV_RST); else pass_cnt++;
    rd(8'h00, r); total_cnt++;
    if (r !== 32'd0) $display("FAIL mid_ctrl_reset: got %h required 0", r); else pass_cnt++;
    rd(8'h0C, r); total_cnt++;
    if (r !== 32'd0) $display("FAIL mid_status_reset: got %h required 0", r); else pass_cnt++;
    rd(8'h08, r); total_cnt++;
    if (r !== 32'd0) $display("FAIL mid_rx_reset: got %h required 0", r); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_loopback();
    test_fixed_pattern();
    test_random_xfers();
    test_overrun();
    test_div_during_busy();
    test_abort();
    test_irq();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_wb_master.md
SPI_WB_MASTER -- requirements
Module: spi_wb_master

Interface
REQ-001 SHALL have parameter DIV_RST, default 8'd3, reset value of the DIV register.
REQ-002 SHALL have port CLK_I, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port RST_I, input, 1, reset: synchronous and active-high.
REQ-004 SHALL have port ADR_I, input, 8, Wishbone byte address; only ADR_I[3:2] is decoded, and only when ADR_I[7:4]=0.
REQ-005 SHALL have ports DAT_I (input, 32, write data) and DAT_O (output, 32, read data).
REQ-006 SHALL have ports CYC_I, STB_I and WE_I (each input, 1), the Wishbone cycle, strobe and write-enable.
REQ-007 SHALL have port ACK_O, output, 1, Wishbone acknowledge.
REQ-008 SHALL have SPI ports SCLK_O (out, 1), MOSI_O (out, 1), MISO_I (in, 1) and SS_O (out, 1, active-low).
REQ-009 SHALL have port IRQ_O, output, 1, transfer-done interrupt.

Function
REQ-010 SHALL register ACK_O as CYC_I & STB_I & ~ACK_O, giving 1-cycle latency and a 1-cycle pulse; a request held high is acked every other cycle.
REQ-011 SHALL apply writes, and read side effects, only in the cycle ACK_O=1; DAT_O is valid in the ACK cycle and 0 otherwise.
REQ-012 Register map:
- 0x00 CTRL[3:0] R/W: EN, SSM (manual select), IE, ASS (auto select).
- 0x04 DIV[7:0] R/W.
- 0x08 DATA: a write loads TX[7:0]; a read returns RX[7:0] and clears DONE.
- 0x0C STATUS, read: {OVR, DONE, BUSY} at bits [2:0]; a write of 1 to bit1 or bit2 clears the matching bit.
- Unmapped addresses: acked, read 0, write ignored.
REQ-013 SHALL use FSM states IDLE, SHIFT and FINISH; BUSY=1 in SHIFT and FINISH.
REQ-014 IDLE->SHIFT occurs on a DATA write while EN=1; the FSM is in SHIFT the cycle after the ACK.
- On that transition: latch TX into the shift register and DIV into the active divisor.
- Also on that transition: MOSI_O = TX[7], SCLK_O = 0.
REQ-015 A DATA write with EN=0 SHALL update TX only, with no transfer.
REQ-016 A DATA write while BUSY SHALL be dropped (TX unchanged) and set OVR.
REQ-017 In SHIFT, SCLK_O SHALL toggle every DIV+1 clocks, 16 toggles total, using SPI mode 0, MSB first.
- Rising toggles: sample MISO_I into the receive shift register.
- Falling toggles 1..7: drive the next TX bit onto MOSI_O.
REQ-018 After the 16th toggle (SCLK_O low), the FSM SHALL enter FINISH for 1 cycle.
- In FINISH: RX <= received byte and DONE <= 1.
- Next state is IDLE.
- Total BUSY time is 16*(DIV+1)+1 cycles.
REQ-019 A DIV write during BUSY SHALL affect only the next transfer.
REQ-020 If EN is cleared in SHIFT, the FSM SHALL go to IDLE next cycle.
- SCLK_O = 0, RX and DONE unchanged.
- Remaining bits are discarded.
REQ-021 SS_O SHALL be ~(SSM | (ASS & BUSY)).
REQ-022 MOSI_O SHALL hold its last value in IDLE.
REQ-023 If DONE set (FINISH) and DONE clear (DATA read or STATUS write) happen in the same cycle, set SHALL win.
REQ-024 IRQ_O SHALL be registered as IE & DONE, i.e. valid 1 cycle after DONE.

Reset
REQ-025 RST_I=1 at a clock edge SHALL force IDLE from any state, including mid-transfer.
REQ-026 Reset values SHALL be:
- ACK_O=0, DAT_O=0.
- SCLK_O=0, MOSI_O=0, SS_O=1, IRQ_O=0.
- CTRL=0, DIV=DIV_RST, TX=0, RX=0.
- BUSY, DONE and OVR all 0.
REQ-027 A Wishbone request present during reset SHALL NOT be acked; ACK_O is first possible 1 cycle after RST_I falls.

Verification
REQ-028 Loopback (MOSI_O->MISO_I), CTRL=0x9, DIV=0, write DATA=0xA5 -> SS_O low for 17 cycles, 8 SCLK pulses, each 1 clk high/1 clk low; then STATUS=0x2, DATA read=0xA5, STATUS=0x0.
REQ-029 DIV=3, MISO_I tied 1, write DATA=0x3C -> MOSI_O bit sequence 0,0,1,1,1,1,0,0; BUSY for 65 cycles; RX=0xFF.
REQ-030 DATA write 0x11 during a transfer -> STATUS.OVR=1, received/sent byte unchanged; writing STATUS=0x4 -> OVR=0.
REQ-031 Clear EN at the 5th SCLK toggle -> IDLE next cycle, SCLK_O=0, DONE=0, RX keeps its old value.
REQ-032 RST_I pulse mid-transfer with CTRL=0xF -> next cycle all outputs at reset values, SS_O=1, IRQ_O=0, DIV reads DIV_RST.
REQ-033 IE=1, transfer completes -> IRQ_O rises 1 cycle after FINISH; DATA read in the same cycle as FINISH -> DONE stays 1.
